// File: rtl/ex_divider.sv
// Multi-cycle radix-2 restoring divider for the EX stage. It handles DIV/DIVU/REM/REMU,
// resolves divide-by-zero and signed overflow without iterating, and stalls the front end while it computes.
module ex_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        stall_out,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  count;
  logic [31:0] quo, rem, dvs;
  logic        is_rem_q, neg_q, neg_r;
  logic [4:0]  rd_q;

  logic        accept, is_signed, div_zero, overflow, special;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted, diff;
  logic        fits;
  logic [31:0] quo_next, rem_next, quo_final, rem_final, res_next;

  assign accept    = (state == IDLE) && start && !flush;
  assign is_signed = ~op[0];
  assign abs_a     = (is_signed && rs1_data[31]) ? (32'd0 - rs1_data) : rs1_data;
  assign abs_b     = (is_signed && rs2_data[31]) ? (32'd0 - rs2_data) : rs2_data;
  assign div_zero  = (rs2_data == 32'd0);
  assign overflow  = is_signed && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  assign special   = div_zero || overflow;

  // One restoring step: shift the next dividend bit into the partial remainder and subtract if it fits.
  assign shifted   = {rem, quo[31]};
  assign diff      = shifted - {1'b0, dvs};
  assign fits      = ~diff[32];
  assign rem_next  = fits ? diff[31:0] : shifted[31:0];
  assign quo_next  = {quo[30:0], fits};
  assign quo_final = neg_q ? (32'd0 - quo) : quo;
  assign rem_final = neg_r ? (32'd0 - rem) : rem;
  assign res_next  = is_rem_q ? rem_final : quo_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush)              state_next = IDLE;
        else if (count == 6'd31) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    stall_out = rst_n && (accept || (state == CALC));
  end

  // Special cases preload quo/rem so that the common sign-fixup mux yields the architected answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 6'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      dvs      <= 32'd0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rd_q     <= 5'd0;
      done     <= 1'b0;
      result   <= 32'd0;
      rd_out   <= 5'd0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        is_rem_q <= op[1];
        rd_q     <= rd_in;
        count    <= 6'd0;
        if (div_zero) begin
          quo   <= 32'hFFFF_FFFF;
          rem   <= rs1_data;
          dvs   <= 32'd0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (overflow) begin
          quo   <= 32'h8000_0000;
          rem   <= 32'd0;
          dvs   <= 32'd0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          quo   <= abs_a;
          rem   <= 32'd0;
          dvs   <= abs_b;
          neg_q <= is_signed && (rs1_data[31] ^ rs2_data[31]);
          neg_r <= is_signed && rs1_data[31];
        end
      end else if (state == CALC && !flush) begin
        quo   <= quo_next;
        rem   <= rem_next;
        count <= count + 6'd1;
      end else if (state == DONE && !flush) begin
        done   <= 1'b1;
        result <= res_next;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_divider.sv
// Directed-vector bench for ex_divider: results, latency, stall window, flush, reset and start-while-busy behaviour.
module tb_ex_divider;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clk, rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, stall_out, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int assertions = 0;
  int failures   = 0;

  ex_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush), .busy(busy),
    .stall_out(stall_out), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request in the IDLE cycle, checks the combinational stall, and returns just after E0.
  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
    #1;
    checkOutput({tag, "_stall_idle"}, {31'd0, stall_out}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_rd,
                          input int lat);
    int k = 0;
    int stall_hi = 0;
    while (!done && k < 100) begin
      if (stall_out) stall_hi++;
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput({tag, "_latency"}, k, lat);
    checkOutput({tag, "_stall_cycles"}, stall_hi, (lat == 33) ? 32 : 0);
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_rd"}, {27'd0, rd_out}, {27'd0, exp_rd});
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int lat);
    applyStimulus(tag, o, a, b, rd);
    waitDone(tag, exp_res, rd, lat);
  endtask

  initial begin
    int dones;
    clk = 1'b0; rst_n = 1'b0; start = 1'b1; flush = 1'b0;
    op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd5;
    #12;
    checkOutput("rst_busy",   {31'd0, busy},      32'd0);
    checkOutput("rst_done",   {31'd0, done},      32'd0);
    checkOutput("rst_stall",  {31'd0, stall_out}, 32'd0);
    checkOutput("rst_result", result,             32'd0);
    checkOutput("rst_rd",     {27'd0, rd_out},    32'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;

    runOp("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33);
    runOp("remu_100_7",   OP_REMU, 32'd100,        32'd7,          5'd6,  32'd2,          33);
    runOp("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  33);
    runOp("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  33);
    runOp("div_7_m2",     OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD,  33);
    runOp("rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd10, 32'd1,          33);
    runOp("div_min_2",    OP_DIV,  32'h8000_0000,  32'd2,          5'd11, 32'hC000_0000,  33);
    runOp("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd12, 32'hFFFF_FFFF,  33);
    runOp("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  1);
    runOp("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          1);
    runOp("divu_5_0",     OP_DIVU, 32'd5,          32'd0,          5'd15, 32'hFFFF_FFFF,  1);
    runOp("remu_5_0",     OP_REMU, 32'd5,          32'd0,          5'd16, 32'd5,          1);
    runOp("div_5_0",      OP_DIV,  32'd5,          32'd0,          5'd17, 32'hFFFF_FFFF,  1);
    runOp("rem_m7_0",     OP_REM,  32'hFFFF_FFF9,  32'd0,          5'd18, 32'hFFFF_FFF9,  1);

    // Flush 10 cycles into CALC: no completion, previous result (0xFFFFFFF9, rd 18) survives.
    applyStimulus("flush", OP_DIVU, 32'd1000, 32'd10, 5'd9);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checkOutput("flush_no_done", dones, 0);
    checkOutput("flush_result", result, 32'hFFFF_FFF9);
    checkOutput("flush_rd", {27'd0, rd_out}, 32'd18);
    runOp("after_flush", OP_DIVU, 32'd1000, 32'd10, 5'd9, 32'd100, 33);

    // start held high through most of CALC must not queue a second operation.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3;
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (i == 20) start = 1'b0;
      if (done) dones++;
    end
    checkOutput("held_start_dones", dones, 1);
    checkOutput("held_start_result", result, 32'd14);

    // Asynchronous reset in the middle of CALC clears every output immediately.
    applyStimulus("reset_mid", OP_DIVU, 32'd1000, 32'd10, 5'd9);
    repeat (10) @(posedge clk);
    #2;
    start = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",   {31'd0, busy},      32'd0);
    checkOutput("midrst_done",   {31'd0, done},      32'd0);
    checkOutput("midrst_stall",  {31'd0, stall_out}, 32'd0);
    checkOutput("midrst_result", result,             32'd0);
    checkOutput("midrst_rd",     {27'd0, rd_out},    32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checkOutput("midrst_no_done", dones, 0);
    runOp("after_reset", OP_REMU, 32'd1000, 32'd7, 5'd21, 32'd6, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/ex_divider.md
EX_DIVIDER -- requirements
Module: ex_divider

Interface
REQ-001 The port list SHALL be exactly as follows (name, direction, width, meaning), clock and reset first.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  EX-stage divide request; operands are valid in the same cycle.
REQ-005 op  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 rs1_data  in  32  dividend.
REQ-007 rs2_data  in  32  divisor.
REQ-008 rd_in  in  5  destination register tag.
REQ-009 flush  in  1  synchronous abort from branch/exception logic.
REQ-010 busy  out  1  high while the state is not IDLE.
REQ-011 stall_out  out  1  hold request to PC, IF/ID and ID/EX.
REQ-012 done  out  1  one-cycle result-valid pulse.
REQ-013 result  out  32  quotient or remainder.
REQ-014 rd_out  out  5  tag of the completed operation.

Function
REQ-015 The block SHALL implement the states IDLE, CALC and DONE, with a 6-bit iteration counter.
REQ-016 In IDLE, start=1 with flush=0 SHALL be accepted at edge E0, which latches op, rd_in and operand magnitudes.
REQ-017 After acceptance the block SHALL take one of two paths.
- Special case (divisor==0, or DIV/REM with 0x80000000 / 0xFFFFFFFF): go to DONE at E0.
- Otherwise: go to CALC at E0.
REQ-018 CALC SHALL perform one restoring radix-2 iteration per edge on unsigned magnitudes and enter DONE after exactly 32 iterations.
REQ-019 Latency SHALL be done rising at E0+1 for special cases and at E0+33 for normal cases.
- done is high for exactly one cycle.
- The state returns to IDLE on the following edge.
REQ-020 result and rd_out SHALL be registered and updated on the edge that raises done.
- Both hold their value until the next completion.
REQ-021 Signed ops (DIV, REM) SHALL follow these rules.
- Quotient truncates toward zero.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-022 Divide-by-zero SHALL return:
- DIV and DIVU: 0xFFFFFFFF.
- REM and REMU: the dividend, unmodified.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL return DIV = 0x80000000 and REM = 0x00000000.
REQ-024 stall_out SHALL be combinational and asserted in two cases, and SHALL be low in DONE so the pipeline advances with the result.
- In IDLE when start=1 and flush=0.
- Throughout CALC.
REQ-025 start SHALL be ignored while busy=1; no request is queued.
REQ-026 flush SHALL take priority over start, CALC progress and DONE.
- The state goes to IDLE at the next edge.
- No done pulse is produced.
- result and rd_out are left unchanged.
REQ-027 After returning to IDLE, start in that IDLE cycle SHALL be accepted, which allows back-to-back operations.

Reset
REQ-028 rst_n=0 SHALL immediately force the following, including mid-CALC or mid-DONE; no partial result may survive.
- State IDLE, counter 0.
- busy=0, done=0, result=0, rd_out=0.
- All internal operand registers 0.
REQ-029 stall_out SHALL be 0 while rst_n=0.

Verification
REQ-030 DIVU 100/7, rd_in=5 -> stall_out high E0..E32, done only at E0+33, result=14, rd_out=5; same operands with REMU -> result=2.
REQ-031 DIV 0xFFFFFFF9(-7)/2 -> result=0xFFFFFFFD; REM -> result=0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> done at E0+1, result=0x80000000; REM -> 0x00000000.
REQ-033 DIVU 5/0 -> done at E0+1, result=0xFFFFFFFF; REMU 5/0 -> result=5.
REQ-034 flush asserted 10 cycles into CALC -> busy=0 next edge, no done, result keeps its prior value; a new start then completes normally.
REQ-035 rst_n pulsed low mid-CALC -> all outputs 0 asynchronously; start held high during CALC (no reset) -> ignored, exactly one done.
